// File: rtl/audio_i2s_rx.sv
// I2S slave receiver: synchronises SCK/WS/SDATA into clk_i, frames 16-bit
// left/right samples and queues {left, right} words on a stream output.
module audio_i2s_rx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i2s_sck_i,
    input  logic        i2s_ws_i,
    input  logic        i2s_sdata_i,
    input  logic        outport_tready_i,
    output logic        outport_tvalid_o,
    output logic [31:0] outport_tdata_o,
    output logic [3:0]  outport_tstrb_o,
    output logic [3:0]  outport_tdest_o,
    output logic        outport_tlast_o,
    output logic        overflow_o,
    output logic        sync_lost_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LAST  = SYNC_STAGES - 1;
    localparam logic [PTR_W:0] PTR_INC = {{PTR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_e;

    // Synchroniser chains and edge detector history
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   sck_rise_s;

    // Framing state
    state_e      state_q, state_d;
    logic        ws_q1_q, ws_q1_d;
    logic        ws_q2_q, ws_q2_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] left_q, left_d;
    logic        push_q, push_d;
    logic [31:0] push_data_q, push_data_d;
    logic        sync_lost_q, sync_lost_d;

    // Scratch values for the strobe cycle
    logic        bit_s;
    logic        ch_s;
    logic        msb_s;
    logic [15:0] shift_in_s;

    // Output FIFO
    logic [31:0]    mem_q [FIFO_DEPTH];
    logic [31:0]    mem_d [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           overflow_q, overflow_d;
    logic           full_s;
    logic           empty_s;
    logic           pop_s;

    // Shift the I2S pins through the synchronisers and detect SCK rising edges
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], i2s_sck_i};
        ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], i2s_ws_i};
        sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata_i};
        sck_prev_d = sck_sync_q[LAST];
        sck_rise_s = sck_sync_q[LAST] & ~sck_prev_q;
    end

    // Framing FSM: WS history decides channel and MSB, bits counted per channel
    always_comb begin
        state_d     = state_q;
        ws_q1_d     = ws_q1_q;
        ws_q2_d     = ws_q2_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_d      = left_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        sync_lost_d = 1'b0;
        // Data lags WS by one SCK, so the bit seen now belongs to the WS seen last rise
        bit_s       = sd_sync_q[LAST];
        ch_s        = ws_q1_q;
        msb_s       = (ws_q1_q != ws_q2_q);
        shift_in_s  = {shift_q[14:0], bit_s};
        if (sck_rise_s) begin
            ws_q1_d = ws_sync_q[LAST];
            ws_q2_d = ws_q1_q;
            case (state_q)
                ST_HUNT: begin
                    if (msb_s && !ch_s) begin
                        state_d   = ST_LEFT;
                        bit_cnt_d = 5'd1;
                        shift_d   = {15'd0, bit_s};
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_LEFT: begin
                    if (msb_s && ch_s) begin
                        if (bit_cnt_q == 5'd16) begin
                            state_d   = ST_RIGHT;
                            bit_cnt_d = 5'd1;
                            shift_d   = {15'd0, bit_s};
                        end else begin
                            sync_lost_d = 1'b1;
                            state_d     = ST_HUNT;
                            bit_cnt_d   = 5'd0;
                        end
                    end else if (msb_s) begin
                        // Left restarted without a right channel: resynchronise on it
                        bit_cnt_d = 5'd1;
                        shift_d   = {15'd0, bit_s};
                    end else if (bit_cnt_q < 5'd16) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            left_d = shift_in_s;
                        end else begin
                            left_d = left_q;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_RIGHT: begin
                    if (msb_s && !ch_s) begin
                        if (bit_cnt_q == 5'd16) begin
                            push_d      = 1'b1;
                            push_data_d = {left_q, shift_q};
                            state_d     = ST_LEFT;
                            bit_cnt_d   = 5'd1;
                            shift_d     = {15'd0, bit_s};
                        end else begin
                            sync_lost_d = 1'b1;
                            state_d     = ST_HUNT;
                            bit_cnt_d   = 5'd0;
                        end
                    end else if (msb_s) begin
                        bit_cnt_d = 5'd1;
                        shift_d   = {15'd0, bit_s};
                    end else if (bit_cnt_q < 5'd16) begin
                        shift_d   = shift_in_s;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        shift_d = shift_q;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    bit_cnt_d = 5'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FIFO bookkeeping: a pop frees the slot before a same-cycle push into a full FIFO
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = 1'b0;
        empty_s    = (wr_ptr_q == rd_ptr_q);
        full_s     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop_s      = !empty_s && outport_tready_i;
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_INC;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_q) begin
            if (!full_s || pop_s) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = push_data_q;
                wr_ptr_d                   = wr_ptr_q + PTR_INC;
            end else begin
                overflow_d = 1'b1;
            end
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // State registers for synchronisers, framing and FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync_q  <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            state_q     <= ST_HUNT;
            ws_q1_q     <= 1'b0;
            ws_q2_q     <= 1'b0;
            bit_cnt_q   <= 5'd0;
            shift_q     <= 16'd0;
            left_q      <= 16'd0;
            push_q      <= 1'b0;
            push_data_q <= 32'd0;
            sync_lost_q <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ws_sync_q   <= ws_sync_d;
            sd_sync_q   <= sd_sync_d;
            sck_prev_q  <= sck_prev_d;
            state_q     <= state_d;
            ws_q1_q     <= ws_q1_d;
            ws_q2_q     <= ws_q2_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_q      <= left_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            sync_lost_q <= sync_lost_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign outport_tvalid_o = (wr_ptr_q != rd_ptr_q);
    assign outport_tdata_o  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign outport_tstrb_o  = 4'hF;
    assign outport_tdest_o  = 4'h0;
    assign outport_tlast_o  = 1'b1;
    assign overflow_o       = overflow_q;
    assign sync_lost_o      = sync_lost_q;

endmodule

// File: doc/audio_i2s_rx.md
Name: audio_i2s_rx

Overview:
- I2S slave receiver. Samples externally driven SCK/WS/SDATA in the clk_i domain and assembles 16-bit left/right pairs into 32-bit words.
- Words are presented on an AXI-Stream style output port through a small FIFO.
- Sits on the capture path opposite the I2S transmitter, using the same framing: 32 SCK per stereo frame, WS=0 left, WS=1 right, SDATA lagging WS by one SCK, MSB first, packed word {left[15:0], right[15:0]}.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, synchroniser flops on each I2S input; minimum 2.

Ports:
- clk_i  input  1  system clock; must be at least 6x the SCK frequency.
- rst_ni  input  1  asynchronous active-low reset.
- i2s_sck_i  input  1  external bit clock; asynchronous to clk_i.
- i2s_ws_i  input  1  word select: 0 = left, 1 = right.
- i2s_sdata_i  input  1  serial data.
- outport_tready_i  input  1  downstream accept.
- outport_tvalid_o  output  1  FIFO non-empty.
- outport_tdata_o  output  32  {left, right} at FIFO head.
- outport_tstrb_o  output  4  constant 4'hF.
- outport_tdest_o  output  4  constant 4'h0.
- outport_tlast_o  output  1  constant 1.
- overflow_o  output  1  one-cycle pulse when a completed word is dropped because the FIFO is full.
- sync_lost_o  output  1  one-cycle pulse when a channel ends short (fewer than 16 bits).

Behaviour:
- Reset (rst_ni=0, async):
  - FIFO emptied; outport_tvalid_o=0, outport_tdata_o=0.
  - overflow_o=0, sync_lost_o=0.
  - Synchronisers cleared to 0; state=HUNT; bit counter, shift register and left latch cleared.
  - Reset mid-frame discards any partial word. The block re-hunts after deassertion.
- Input sync: SCK, WS and SDATA each pass through SYNC_STAGES flops.
  - An SCK rise is detected when synced SCK is 1 and its previous value was 0; this produces a one-cycle strobe.
  - Pin-to-strobe latency is SYNC_STAGES+1 clk_i cycles.
  - WS and SDATA are sampled on the strobe cycle from their synced values.
- Per SCK rise:
  - ws_q1 <= ws_sampled; ws_q2 <= ws_q1.
  - The bit sampled now belongs to channel ws_q1.
  - It is the MSB when ws_q1 != ws_q2 (WS changed one SCK earlier).
- State machine, advanced only on SCK-rise strobes:
  - HUNT: ignore data. On an MSB of channel 0, go to LEFT with bit_cnt=1 and shift={15'b0,bit}. Any right-channel MSB keeps HUNT.
  - LEFT:
    - While bit_cnt<16: shift in, bit_cnt++.
    - When bit_cnt reaches 16: latch left <= shift. Further bits are ignored until the next MSB.
    - On a right MSB with bit_cnt==16: go to RIGHT, bit_cnt=1.
    - On a right MSB with bit_cnt<16: pulse sync_lost_o, go to HUNT.
  - RIGHT:
    - Collect bits identically.
    - On a left MSB with bit_cnt==16: push {left, shift} into the FIFO. Stay synchronised: go to LEFT with bit_cnt=1, the MSB loaded.
    - On a left MSB with bit_cnt<16: pulse sync_lost_o, go to HUNT. The pair is not pushed.
- Push timing: the push occurs on the clk_i cycle after the strobe carrying the next left MSB. outport_tvalid_o rises the following cycle.
  - Consequence: a stereo pair is delivered only once the next frame starts.
  - Frames longer than 32 SCK are accepted; bits beyond 16 per channel are ignored.
- FIFO:
  - Pop when outport_tvalid_o && outport_tready_i.
  - Push when full: the word is dropped, overflow_o pulses, and FIFO contents are unchanged.
  - Simultaneous push and pop when full: the pop occurs first, the push succeeds, and there is no overflow.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
  - outport_tdata_o is stable while tvalid=1 and tready=0.
- No glitch filtering beyond the synchronisers. A WS toggle without a preceding SCK rise is seen only at the next rise.

Test Plan:
1. Reset, then 3 clean frames: L=16'hA5C3, R=16'h1234; then L=16'hFFFF, R=16'h0001; then L=0, R=0 (SCK=clk/8). With tready=1, expect two beats: 32'hA5C31234, then 32'hFFFF0001. tlast=1, tstrb=4'hF, no pulses.
2. Start the stimulus mid-right-channel. The first partial pair must not be emitted; the first output is the first full L/R pair after the WS 1->0 edge.
3. Hold tready=0 with FIFO_DEPTH=4 and send 6 frames. Expect 4 words retained in order, then one overflow_o pulse per later completed pair. After releasing tready, exactly the first 4 pairs drain.
4. Send a left channel with only 10 SCK before WS rises. Expect one sync_lost_o pulse, no output for that frame, and correct output from the following full frame.
5. Assert rst_ni=0 for 1 cycle midway through a right channel. Expect immediate tvalid=0 and FIFO empty. The next output is a pair that started after the re-hunt.
6. With FIFO full, assert tready=1 on the same cycle a push occurs. Expect no overflow_o pulse, tvalid to remain 1, and the new word to appear after the existing 3.
